// File: rtl/ula_8bits.sv
// 8-bit ALU with the 74181 function set (active-high data and carry-in),
// with a combinational result path and a one-cycle registered copy.
module ula_8bits (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       c_out,
    output logic       a_eq_b,
    output logic [7:0] f_q,
    output logic       c_out_q,
    output logic       a_eq_b_q
);

    // First adder operand for each arithmetic select.
    function automatic logic [7:0] arith_x(input logic [3:0] sel,
                                           input logic [7:0] op_a,
                                           input logic [7:0] op_b);
        logic [7:0] x;
        x = 8'h00;
        case (sel)
            4'd0, 4'd4, 4'd6, 4'd8, 4'd9,
            4'd12, 4'd15: x = op_a;
            4'd1, 4'd5, 4'd13: x = op_a | op_b;
            4'd2, 4'd10, 4'd14: x = op_a | ~op_b;
            4'd3:  x = 8'h00;
            4'd7:  x = op_a & ~op_b;
            4'd11: x = op_a & op_b;
            default: x = 8'h00;
        endcase
        return x;
    endfunction

    // Second adder operand for each arithmetic select.
    function automatic logic [7:0] arith_y(input logic [3:0] sel,
                                           input logic [7:0] op_a,
                                           input logic [7:0] op_b);
        logic [7:0] y;
        y = 8'h00;
        case (sel)
            4'd0, 4'd1, 4'd2: y = 8'h00;
            4'd3, 4'd7, 4'd11, 4'd15: y = 8'hFF;
            4'd4, 4'd5: y = op_a & ~op_b;
            4'd6: y = ~op_b;
            4'd8, 4'd10: y = op_a & op_b;
            4'd9: y = op_b;
            4'd12, 4'd13, 4'd14: y = op_a;
            default: y = 8'h00;
        endcase
        return y;
    endfunction

    // Selects whose result is "minus one" style report a borrow, not a carry.
    function automatic logic is_borrow_sel(input logic [3:0] sel);
        return (sel == 4'd3) || (sel == 4'd6) || (sel == 4'd7) ||
               (sel == 4'd11) || (sel == 4'd15);
    endfunction

    function automatic logic [7:0] logic_f(input logic [3:0] sel,
                                           input logic [7:0] op_a,
                                           input logic [7:0] op_b);
        logic [7:0] r;
        r = 8'h00;
        case (sel)
            4'd0:  r = ~op_a;
            4'd1:  r = ~(op_a | op_b);
            4'd2:  r = ~op_a & op_b;
            4'd3:  r = 8'h00;
            4'd4:  r = ~(op_a & op_b);
            4'd5:  r = ~op_b;
            4'd6:  r = op_a ^ op_b;
            4'd7:  r = op_a & ~op_b;
            4'd8:  r = ~op_a | op_b;
            4'd9:  r = ~(op_a ^ op_b);
            4'd10: r = op_b;
            4'd11: r = op_a & op_b;
            4'd12: r = 8'hFF;
            4'd13: r = op_a | ~op_b;
            4'd14: r = op_a | op_b;
            4'd15: r = op_a;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [7:0] op_x;
    logic [7:0] op_y;
    logic [8:0] sum;

    always_comb begin
        op_x = arith_x(s, a, b);
        op_y = arith_y(s, a, b);
        sum  = {1'b0, op_x} + {1'b0, op_y} + {8'h00, c_in};
    end

    always_comb begin
        f     = 8'h00;
        c_out = 1'b0;
        if (m) begin
            f     = logic_f(s, a, b);
            c_out = 1'b0;
        end else begin
            f     = sum[7:0];
            c_out = is_borrow_sel(s) ? ~sum[8] : sum[8];
        end
        a_eq_b = (f == 8'hFF);
    end

    // Registered stage: loads every cycle, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q      <= 8'h00;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
        end else begin
            f_q      <= f;
            c_out_q  <= c_out;
            a_eq_b_q <= a_eq_b;
        end
    end

endmodule

// File: tb/tb_ula_8bits.sv
// Directed and random checks of ula_8bits: combinational outputs checked
// immediately, registered outputs via an expected-value queue.
module tb_ula_8bits;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [7:0] f;
    logic       c_out;
    logic       a_eq_b;
    logic [7:0] f_q;
    logic       c_out_q;
    logic       a_eq_b_q;

    typedef struct packed {
        logic [7:0] f;
        logic       c;
        logic       eq;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   passed;

    ula_8bits dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
        .f(f), .c_out(c_out), .a_eq_b(a_eq_b),
        .f_q(f_q), .c_out_q(c_out_q), .a_eq_b_q(a_eq_b_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
        total++;
        assert (obs === req) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, req);
    endtask

    // Reference model written from the function tables using integer math.
    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic [3:0] ms, input logic mm, input logic mc);
        exp_t e;
        int   x, y, r, ia, ib, nb;
        ia = int'(ma);
        ib = int'(mb);
        nb = 255 - ib;
        e  = '0;
        if (mm) begin
            case (ms)
                0:  r = 255 - ia;
                1:  r = 255 - (ia | ib);
                2:  r = (255 - ia) & ib;
                3:  r = 0;
                4:  r = 255 - (ia & ib);
                5:  r = nb;
                6:  r = ia ^ ib;
                7:  r = ia & nb;
                8:  r = (255 - ia) | ib;
                9:  r = 255 - (ia ^ ib);
                10: r = ib;
                11: r = ia & ib;
                12: r = 255;
                13: r = ia | nb;
                14: r = ia | ib;
                default: r = ia;
            endcase
            e.f = 8'(r);
            e.c = 1'b0;
        end else begin
            case (ms)
                0:  begin x = ia;        y = 0;         end
                1:  begin x = ia | ib;   y = 0;         end
                2:  begin x = ia | nb;   y = 0;         end
                3:  begin x = 0;         y = 255;       end
                4:  begin x = ia;        y = ia & nb;   end
                5:  begin x = ia | ib;   y = ia & nb;   end
                6:  begin x = ia;        y = nb;        end
                7:  begin x = ia & nb;   y = 255;       end
                8:  begin x = ia;        y = ia & ib;   end
                9:  begin x = ia;        y = ib;        end
                10: begin x = ia | nb;   y = ia & ib;   end
                11: begin x = ia & ib;   y = 255;       end
                12: begin x = ia;        y = ia;        end
                13: begin x = ia | ib;   y = ia;        end
                14: begin x = ia | nb;   y = ia;        end
                default: begin x = ia;   y = 255;       end
            endcase
            r   = x + y + int'(mc);
            e.f = 8'(r % 256);
            if (ms inside {4'd3, 4'd6, 4'd7, 4'd11, 4'd15})
                e.c = (r < 256);
            else
                e.c = (r >= 256);
        end
        e.eq = (e.f == 8'hFF);
        return e;
    endfunction

    // Drive one vector, check combinational outputs, then registered ones.
    task automatic step(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [3:0] ts, input logic tm, input logic tc);
        exp_t e;
        exp_t got;
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; c_in = tc;
        e = model(ta, tb, ts, tm, tc);
        sb_q.push_back(e);
        #1;
        check({tag, ".f"}, f, e.f);
        check({tag, ".c_out"}, {7'd0, c_out}, {7'd0, e.c});
        check({tag, ".a_eq_b"}, {7'd0, a_eq_b}, {7'd0, e.eq});
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, ".f_q"}, f_q, got.f);
        check({tag, ".c_out_q"}, {7'd0, c_out_q}, {7'd0, got.c});
        check({tag, ".a_eq_b_q"}, {7'd0, a_eq_b_q}, {7'd0, got.eq});
    endtask

    // Directed vector with hand-derived expectations for the combinational path.
    task automatic direct(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [3:0] ts, input logic tm, input logic tc,
                          input logic [7:0] ef, input logic ec, input logic eeq);
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; c_in = tc;
        #1;
        check({tag, ".f"}, f, ef);
        check({tag, ".c_out"}, {7'd0, c_out}, {7'd0, ec});
        check({tag, ".a_eq_b"}, {7'd0, a_eq_b}, {7'd0, eeq});
    endtask

    initial begin
        logic [7:0] sweep [16];
        total  = 0;
        passed = 0;
        rst = 1'b1; a = 8'h00; b = 8'h00; s = 4'd0; m = 1'b0; c_in = 1'b0;
        #2;
        check("rst.f_q", f_q, 8'h00);
        check("rst.c_out_q", {7'd0, c_out_q}, 8'h00);
        check("rst.a_eq_b_q", {7'd0, a_eq_b_q}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        direct("add_cin",   8'hFF, 8'h00, 4'd0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        direct("pass_a",    8'hC3, 8'h00, 4'd0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0);
        direct("add_ab",    8'hC3, 8'hF0, 4'd9, 1'b0, 1'b0, 8'hB3, 1'b1, 1'b0);
        direct("sub_borrow",8'h01, 8'hC3, 4'd6, 1'b0, 1'b1, 8'h3E, 1'b1, 1'b0);
        direct("cmp_eq",    8'h5A, 8'h5A, 4'd6, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
        direct("cmp_ne",    8'h5A, 8'h5B, 4'd6, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
        direct("minus1",    8'h00, 8'h00, 4'd3, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
        direct("minus1_c",  8'h00, 8'h00, 4'd3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        direct("logic_cin", 8'h5A, 8'h33, 4'd15, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);

        sweep = '{8'hA5, 8'h84, 8'h21, 8'h00, 8'hED, 8'hCC, 8'h69, 8'h48,
                  8'hB7, 8'h96, 8'h33, 8'h12, 8'hFF, 8'hDE, 8'h7B, 8'h5A};
        for (int i = 0; i < 16; i++)
            direct($sformatf("logic_s%0d", i), 8'h5A, 8'h33, 4'(i), 1'b1, 1'b0,
                   sweep[i], 1'b0, (i == 12));

        for (int i = 0; i < 32; i++)
            step($sformatf("all_m%0d_s%0d", i / 16, i % 16), 8'hA7, 8'h3C,
                 4'(i % 16), 1'(i / 16), 1'(i % 3 == 0));
        for (int i = 0; i < 60; i++)
            step($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));

        step("reg_load", 8'h10, 8'h20, 4'd9, 1'b0, 1'b0);
        check("reg_load.value", f_q, 8'h30);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst.f_q", f_q, 8'h00);
        check("async_rst.c_out_q", {7'd0, c_out_q}, 8'h00);
        check("async_rst.comb_f", f, 8'h30);
        @(posedge clk);
        #1;
        check("rst_hold.f_q", f_q, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release.f_q", f_q, 8'h00);
        @(posedge clk);
        #1;
        check("reload.f_q", f_q, 8'h30);
        check("scoreboard_empty", 8'(sb_q.size()), 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
